// File: rtl/f2c_dma_writer_pkg.sv
// rtl/f2c_dma_writer_pkg.sv - shared constants, FSM state type and MWr TLP header helpers for the F2C DMA writer
package f2c_dma_writer_pkg;

  localparam int F2C_CHUNKSIZE_NBITS = 9;
  localparam int F2C_NUMCHUNKS_NBITS = 3;
  localparam int F2C_MAXPAY_NBITS    = 7;

  typedef logic [63:0] uint64;
  typedef logic [F2C_NUMCHUNKS_NBITS-1:0] CBPtr;

  typedef enum logic [1:0] {
    H3DW_NODATA   = 2'b00,
    H4DW_NODATA   = 2'b01,
    H3DW_WITHDATA = 2'b10,
    H4DW_WITHDATA = 2'b11
  } TlpFmt;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WAIT, S_MTR0, S_MTR1, S_MTR2
  } F2cState;

  // QW0 of an MWr: DW0 in the low half, DW1 (reqID/tag/BEs) in the high half
  function automatic uint64 genDmaWrite0(logic [15:0] reqID, logic [9:0] dwCount,
                                         TlpFmt fmt, logic [3:0] lastBE);
    return {reqID, 8'h00, lastBE, 4'hF, 1'b0, fmt, 5'b00000, 14'h0000, dwCount};
  endfunction

  function automatic uint64 genDmaWrite1_64(uint64 addr);
    return {addr[31:0], addr[63:32]};
  endfunction

  function automatic TlpFmt fmtFor(uint64 addr);
    return (addr[63:32] != 32'h0) ? H4DW_WITHDATA : H3DW_WITHDATA;
  endfunction

  function automatic uint64 genDmaHdr1(uint64 addr);
    return (addr[63:32] != 32'h0) ? genDmaWrite1_64(addr) : {32'h0, addr[31:0]};
  endfunction

  // Generic over pointer width so the top can be parametrised independently
  function automatic logic isFull(logic [15:0] wr, logic [15:0] rd, int nbits);
    logic [15:0] mask;
    mask = 16'((32'd1 << nbits) - 32'd1);
    return ((wr + 16'd1) & mask) == (rd & mask);
  endfunction

endpackage

// File: rtl/f2c_dma_writer_if.sv
// rtl/f2c_dma_writer_if.sv - 64-bit TX stream towards the tlp_xcvr arbiter
interface f2c_dma_writer_if;
  logic [63:0] txData;
  logic        txValid;
  logic        txReady;
  logic        txSOP;
  logic        txEOP;

  modport master (output txData, txValid, txSOP, txEOP, input txReady);
  modport slave  (input txData, txValid, txSOP, txEOP, output txReady);
endinterface

// File: rtl/f2c_dma_writer.sv
// rtl/f2c_dma_writer.sv - F2C FIFO to host circular buffer DMA engine emitting posted MWr TLPs
// F2C_MTR_UPDATE_EN adds a 1-DW pointer write to mtrBase_in after every chunk.
module f2c_dma_writer
  import f2c_dma_writer_pkg::*;
#(
  parameter int CHUNKSIZE_NBITS = F2C_CHUNKSIZE_NBITS,
  parameter int NUMCHUNKS_NBITS = F2C_NUMCHUNKS_NBITS,
  parameter int MAXPAY_NBITS    = F2C_MAXPAY_NBITS
) (
  input  logic                         pcieClk_in,
  input  logic                         pcieRst_n_in,
  input  logic [15:0]                  cfgBusID_in,
  input  logic                         dmaEnable_in,
  input  logic [63:0]                  f2cBase_in,
  input  logic [NUMCHUNKS_NBITS-1:0]   f2cRdPtr_in,
  output logic [NUMCHUNKS_NBITS-1:0]   f2cWrPtr_out,
  input  logic [63:0]                  f2cData_in,
  input  logic [CHUNKSIZE_NBITS-3:0]   f2cLevel_in,
  output logic                         f2cRead_out,
`ifdef F2C_MTR_UPDATE_EN
  input  logic [63:0]                  mtrBase_in,
`endif
  output logic                         busy_out,
  f2c_dma_writer_if.master             tx
);

  localparam int P      = 2 ** (MAXPAY_NBITS - 3);
  localparam int BEAT_W = (MAXPAY_NBITS > 3) ? MAXPAY_NBITS - 3 : 1;
  localparam int OFF_W  = (CHUNKSIZE_NBITS > MAXPAY_NBITS) ? CHUNKSIZE_NBITS - MAXPAY_NBITS : 1;
  localparam int TLPS   = 2 ** (CHUNKSIZE_NBITS - MAXPAY_NBITS);
  localparam int LVL_PW = CHUNKSIZE_NBITS - 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(P - 1);
  localparam logic [OFF_W-1:0]  LAST_OFF  = OFF_W'(TLPS - 1);
  localparam logic [LVL_PW-1:0] LVL_P     = LVL_PW'(P);
  localparam logic [9:0]        DW_COUNT  = 10'(2 * P);
  localparam logic [63:0]       TLP_BYTES = 64'(P * 8);

  F2cState                      r_state;
  logic [NUMCHUNKS_NBITS-1:0]   r_wr_ptr;
  logic [OFF_W-1:0]             r_offset;
  logic [BEAT_W-1:0]            r_beat;
  logic [63:0]                  r_addr;
  logic [63:0]                  r_hdr;
  logic                         r_valid;
  logic                         r_sop;
  logic                         r_eop;
  logic                         r_busy;

  logic [63:0] w_chunk_addr;
  logic [63:0] w_next_addr;
  logic        w_full;
  logic        w_lvl_ge_p;
  logic        w_lvl_gt_p;
  logic        w_start;

  assign w_chunk_addr = f2cBase_in + (64'(r_wr_ptr) << CHUNKSIZE_NBITS);
  assign w_next_addr  = r_addr + TLP_BYTES;
  assign w_full       = isFull(16'(r_wr_ptr), 16'(f2cRdPtr_in), NUMCHUNKS_NBITS);
  assign w_lvl_ge_p   = ({1'b0, f2cLevel_in} >= LVL_P);
  // Level still counts the head being popped on the last data beat
  assign w_lvl_gt_p   = ({1'b0, f2cLevel_in} > LVL_P);
  assign w_start      = dmaEnable_in && w_lvl_ge_p && !w_full;

  // Payload comes straight from the show-ahead FIFO head; pop only on accepted beats
  assign tx.txData    = (r_state == S_DATA) ? f2cData_in : r_hdr;
  assign tx.txValid   = r_valid;
  assign tx.txSOP     = r_sop;
  assign tx.txEOP     = r_eop;
  assign f2cRead_out  = (r_state == S_DATA) && tx.txReady;
  assign f2cWrPtr_out = r_wr_ptr;
  assign busy_out     = r_busy;

  always_ff @(posedge pcieClk_in or negedge pcieRst_n_in) begin
    if (!pcieRst_n_in) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_offset <= '0;
      r_beat   <= '0;
      r_addr   <= '0;
      r_hdr    <= '0;
      r_valid  <= 1'b0;
      r_sop    <= 1'b0;
      r_eop    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_addr   <= w_chunk_addr;
            r_offset <= '0;
            r_hdr    <= genDmaWrite0(cfgBusID_in, DW_COUNT, fmtFor(w_chunk_addr), 4'hF);
            r_valid  <= 1'b1;
            r_sop    <= 1'b1;
            r_eop    <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_HDR0;
          end
        end
        S_HDR0: begin
          if (tx.txReady) begin
            r_hdr   <= genDmaHdr1(r_addr);
            r_sop   <= 1'b0;
            r_state <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (tx.txReady) begin
            r_beat  <= '0;
            r_eop   <= (P == 1);
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (tx.txReady) begin
            if (r_beat == LAST_BEAT) begin
              r_eop <= 1'b0;
              if (r_offset == LAST_OFF) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
`ifdef F2C_MTR_UPDATE_EN
                r_addr   <= mtrBase_in;
                r_hdr    <= genDmaWrite0(cfgBusID_in, 10'd1, fmtFor(mtrBase_in), 4'h0);
                r_sop    <= 1'b1;
                r_state  <= S_MTR0;
`else
                r_valid  <= 1'b0;
                r_busy   <= 1'b0;
                r_state  <= S_IDLE;
`endif
              end else begin
                r_offset <= r_offset + 1'b1;
                r_addr   <= w_next_addr;
                if (w_lvl_gt_p) begin
                  r_hdr   <= genDmaWrite0(cfgBusID_in, DW_COUNT, fmtFor(w_next_addr), 4'hF);
                  r_sop   <= 1'b1;
                  r_state <= S_HDR0;
                end else begin
                  r_valid <= 1'b0;
                  r_state <= S_WAIT;
                end
              end
            end else begin
              r_beat <= r_beat + 1'b1;
              r_eop  <= ((r_beat + BEAT_W'(1)) == LAST_BEAT);
            end
          end
        end
        // Mid-chunk: enable and fullness are deliberately not re-checked
        S_WAIT: begin
          if (w_lvl_ge_p) begin
            r_hdr   <= genDmaWrite0(cfgBusID_in, DW_COUNT, fmtFor(r_addr), 4'hF);
            r_valid <= 1'b1;
            r_sop   <= 1'b1;
            r_state <= S_HDR0;
          end
        end
`ifdef F2C_MTR_UPDATE_EN
        S_MTR0: begin
          if (tx.txReady) begin
            r_hdr   <= genDmaHdr1(r_addr);
            r_sop   <= 1'b0;
            r_state <= S_MTR1;
          end
        end
        S_MTR1: begin
          if (tx.txReady) begin
            r_hdr   <= {32'(r_wr_ptr), 32'h0};
            r_eop   <= 1'b1;
            r_state <= S_MTR2;
          end
        end
        S_MTR2: begin
          if (tx.txReady) begin
            r_valid <= 1'b0;
            r_eop   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
